chip8_fetch: RTL and testbench

Instruction fetch stage of the CHIP-8 CPU. On a fetch request it reads two consecutive bytes from the shared byte-wide program/data RAM, assembles the big-endian 16-bit opcode and holds it with a valid/ready handshake for the CPU control FSM and the opcode decoder directly downstream. Memory access goes through a request/grant port so the fetch stage can share RAM with FX33/FX55/FX65 and sprite reads.

---
 rtl/chip8_fetch_pkg.sv | 18 +
 rtl/chip8_fetch.sv | 74 +++++++
 tb/tb_chip8_fetch.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/chip8_fetch_pkg.sv
// Shared constants for the CHIP-8 instruction fetch stage: the CPU address width
// and the fetch FSM state encodings.
package chip8_fetch_pkg;

    localparam int CHIP8_ADDR_W = 12;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_HI   = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_RD_LO   = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;
    localparam logic [2:0] S_VALID   = 3'd5;

    function automatic logic is_read_state(input logic [2:0] s);
        return (s == S_RD_HI) || (s == S_RD_LO);
    endfunction

endpackage

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: two byte reads through a request/grant RAM port,
// big-endian opcode held under a valid/ready handshake.
module chip8_fetch
    import chip8_fetch_pkg::*;
#(
    parameter int ADDR_W = CHIP8_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_rdata,
    output logic [15:0]       opcode,
    output logic [ADDR_W-1:0] opcode_pc,
    output logic              opcode_valid,
    input  logic              opcode_ready
);

    logic [2:0]        state_r;
    logic [2:0]        state_nx;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_lo;
    logic [7:0]        hi_r;
    logic [7:0]        lo_r;

    assign pc_lo = pc_r + ADDR_W'(1);

    always_comb begin
        state_nx = state_r;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:    if (fetch_req)    state_nx = S_RD_HI;
                S_RD_HI:   if (mem_gnt)      state_nx = S_WAIT_HI;
                S_WAIT_HI:                   state_nx = S_RD_LO;
                S_RD_LO:   if (mem_gnt)      state_nx = S_WAIT_LO;
                S_WAIT_LO:                   state_nx = S_VALID;
                S_VALID:   if (opcode_ready) state_nx = S_IDLE;
                default:                     state_nx = S_IDLE;
            endcase
        end
    end

    // Captures are suppressed under flush so a read issued before it never lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            pc_r    <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            state_r <= state_nx;
            if (!flush) begin
                if (state_r == S_IDLE && fetch_req) pc_r <= fetch_pc;
                if (state_r == S_WAIT_HI)           hi_r <= mem_rdata;
                if (state_r == S_WAIT_LO)           lo_r <= mem_rdata;
            end
        end
    end

    assign fetch_ready  = (state_r == S_IDLE);
    assign mem_req      = is_read_state(state_r);
    assign mem_addr     = (state_r == S_RD_LO) ? pc_lo : pc_r;
    assign opcode       = {hi_r, lo_r};
    assign opcode_pc    = pc_r;
    assign opcode_valid = (state_r == S_VALID);

endmodule

// File: tb/tb_chip8_fetch.sv
// Self-checking bench for chip8_fetch: RAM model with one-cycle read latency and
// an expected-schedule model of each fetch (addresses, latency, opcode).
module tb_chip8_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [11:0] fetch_pc;
    logic        fetch_ready;
    logic        flush;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_rdata;
    logic [15:0] opcode;
    logic [11:0] opcode_pc;
    logic        opcode_valid;
    logic        opcode_ready;

    logic [7:0]  ram [0:4095];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    chip8_fetch #(.ADDR_W(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rdata    (mem_rdata),
        .opcode       (opcode),
        .opcode_pc    (opcode_pc),
        .opcode_valid (opcode_valid),
        .opcode_ready (opcode_ready)
    );

    // RAM returns the addressed byte the cycle after an issuing edge, garbage otherwise.
    always @(posedge clk) begin
        if (mem_req && mem_gnt) mem_rdata <= ram[mem_addr];
        else                    mem_rdata <= 8'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},  32'(fetch_ready),  32'd1);
        chk({tag, "_req"},    32'(mem_req),      32'd0);
        chk({tag, "_addr"},   32'(mem_addr),     32'd0);
        chk({tag, "_opcode"}, 32'(opcode),       32'd0);
        chk({tag, "_pc"},     32'(opcode_pc),    32'd0);
        chk({tag, "_valid"},  32'(opcode_valid), 32'd0);
    endtask

    // Full fetch with hs/ls grant-less cycles in the two read phases and
    // hold cycles of opcode_ready=0 once the opcode is valid.
    task automatic do_fetch(input logic [11:0] pc, input int unsigned hs,
                            input int unsigned ls, input int unsigned hold);
        logic [11:0] pc1;
        logic [15:0] exp_op;
        pc1    = pc + 12'd1;
        exp_op = {ram[pc], ram[pc1]};
        chk("pre_ready", 32'(fetch_ready), 32'd1);
        fetch_req    = 1'b1;
        fetch_pc     = pc;
        mem_gnt      = 1'($urandom);
        opcode_ready = 1'($urandom);
        step();
        for (int unsigned i = 0; i <= hs; i++) begin
            chk("rd_hi_req",   32'(mem_req),      32'd1);
            chk("rd_hi_addr",  32'(mem_addr),     32'(pc));
            chk("rd_hi_ready", 32'(fetch_ready),  32'd0);
            chk("rd_hi_valid", 32'(opcode_valid), 32'd0);
            fetch_req    = 1'($urandom);
            fetch_pc     = 12'($urandom);
            opcode_ready = 1'($urandom);
            mem_gnt      = (i == hs);
            step();
        end
        chk("wait_hi_req", 32'(mem_req), 32'd0);
        mem_gnt   = 1'($urandom);
        fetch_req = 1'($urandom);
        step();
        for (int unsigned i = 0; i <= ls; i++) begin
            chk("rd_lo_req",   32'(mem_req),      32'd1);
            chk("rd_lo_addr",  32'(mem_addr),     32'(pc1));
            chk("rd_lo_valid", 32'(opcode_valid), 32'd0);
            fetch_req    = 1'($urandom);
            opcode_ready = 1'($urandom);
            mem_gnt      = (i == ls);
            step();
        end
        chk("wait_lo_req",   32'(mem_req),      32'd0);
        chk("wait_lo_valid", 32'(opcode_valid), 32'd0);
        mem_gnt = 1'($urandom);
        step();
        for (int unsigned i = 0; i <= hold; i++) begin
            chk("valid",       32'(opcode_valid), 32'd1);
            chk("opcode",      32'(opcode),       32'(exp_op));
            chk("opcode_pc",   32'(opcode_pc),    32'(pc));
            chk("valid_ready", 32'(fetch_ready),  32'd0);
            chk("valid_req",   32'(mem_req),      32'd0);
            fetch_req    = 1'($urandom);
            fetch_pc     = 12'($urandom);
            mem_gnt      = 1'($urandom);
            opcode_ready = (i == hold);
            step();
        end
        fetch_req    = 1'b0;
        opcode_ready = 1'b0;
        chk("ret_idle_ready", 32'(fetch_ready),  32'd1);
        chk("ret_idle_valid", 32'(opcode_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        ram[12'h200] = 8'h6A; ram[12'h201] = 8'h05;
        ram[12'hFFF] = 8'h12; ram[12'h000] = 8'h34;
        ram[12'h300] = 8'hA2; ram[12'h301] = 8'h2A;
        ram[12'h500] = 8'hFF; ram[12'h501] = 8'hEE;

        reset = 1'b1; fetch_req = 1'b0; fetch_pc = '0; flush = 1'b0;
        mem_gnt = 1'b0; opcode_ready = 1'b0;
        repeat (2) step();
        chk_reset_vals("rst");
        reset = 1'b0;
        step();

        do_fetch(12'h200, 0, 0, 0);
        do_fetch(12'hFFF, 0, 0, 0);
        do_fetch(12'h123, 3, 2, 0);
        do_fetch(12'h2A1, 0, 0, 10);

        // Flush in WAIT_HI drops the fetch.
        fetch_req = 1'b1; fetch_pc = 12'h500; mem_gnt = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ready", 32'(fetch_ready),  32'd1);
        chk("flush_valid", 32'(opcode_valid), 32'd0);
        chk("flush_req",   32'(mem_req),      32'd0);
        step();
        chk("flush_idle_valid", 32'(opcode_valid), 32'd0);
        do_fetch(12'h300, 0, 0, 1);

        // A fetch_req coinciding with flush is not accepted.
        fetch_req = 1'b1; fetch_pc = 12'h300; flush = 1'b1;
        step();
        fetch_req = 1'b0; flush = 1'b0;
        chk("flushreq_ready", 32'(fetch_ready), 32'd1);
        chk("flushreq_req",   32'(mem_req),     32'd0);

        // Asynchronous reset while stalled in RD_LO.
        fetch_req = 1'b1; fetch_pc = 12'h400; mem_gnt = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        mem_gnt = 1'b0;
        step();
        step();
        chk("pre_rst_req",  32'(mem_req),  32'd1);
        chk("pre_rst_addr", 32'(mem_addr), 32'h401);
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        mem_gnt = 1'b1;
        step();
        chk_reset_vals("rst_hold");
        #2;
        reset = 1'b0;
        step();
        do_fetch(12'h400, 1, 0, 0);

        for (int n = 0; n < 10; n++) begin
            do_fetch(12'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
